// File: rtl/serial_frame_aligner.sv
// Frame aligner for a 16-bit SIPO stream: hunts a sync word, then
// slices the following bits into words with a missed-sync flywheel.
module serial_frame_aligner #(
  parameter logic [15:0] SYNC        = 16'hA5C3,
  parameter int          FRAME_WORDS = 4,
  parameter int          MISS_LIMIT  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] sr_word,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [7:0]  word_idx,
  output logic        frame_start,
  output logic        sync_err,
  output logic        locked
);

  typedef enum logic [1:0] {FILL, HUNT, DATA, CHECK} state_t;

  state_t      state, state_n;
  logic [3:0]  fillcnt, fillcnt_n;
  logic [3:0]  bitcnt, bitcnt_n;
  logic [7:0]  wordcnt, wordcnt_n;
  logic [3:0]  miss, miss_n;
  logic [3:0]  miss_inc;
  logic [15:0] dout_n;
  logic [7:0]  widx_n;
  logic        dv_n, fs_n, err_n, lk_n;
  logic        hit, last;

  assign hit      = (sr_word == SYNC);
  assign last     = (bitcnt == 4'd15);
  assign miss_inc = miss + 4'd1;

  always_comb begin
    state_n   = state;
    fillcnt_n = fillcnt;
    bitcnt_n  = bitcnt;
    wordcnt_n = wordcnt;
    miss_n    = miss;
    dout_n    = data_out;
    widx_n    = word_idx;
    dv_n      = 1'b0;
    fs_n      = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      FILL: begin
        fillcnt_n = fillcnt + 4'd1;
        if (fillcnt == 4'd15) state_n = HUNT;
      end
      HUNT: begin
        if (hit) begin
          state_n   = DATA;
          bitcnt_n  = 4'd0;
          wordcnt_n = 8'd0;
          miss_n    = 4'd0;
          fs_n      = 1'b1;
        end
      end
      DATA: begin
        bitcnt_n = bitcnt + 4'd1;
        if (last) begin
          dout_n = sr_word;
          widx_n = wordcnt;
          dv_n   = 1'b1;
          if (wordcnt == 8'(FRAME_WORDS - 1)) begin
            state_n   = CHECK;
            wordcnt_n = 8'd0;
          end else begin
            wordcnt_n = wordcnt + 8'd1;
          end
        end
      end
      CHECK: begin
        bitcnt_n = bitcnt + 4'd1;
        if (last) begin
          if (hit) begin
            miss_n  = 4'd0;
            fs_n    = 1'b1;
            state_n = DATA;
          end else begin
            // flywheel: keep the assumed frame position until the limit
            miss_n  = miss_inc;
            err_n   = 1'b1;
            state_n = (miss_inc == 4'(MISS_LIMIT)) ? HUNT : DATA;
          end
        end
      end
      default: state_n = FILL;
    endcase
    lk_n = (state_n == DATA) || (state_n == CHECK);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= FILL;
      fillcnt     <= 4'd0;
      bitcnt      <= 4'd0;
      wordcnt     <= 8'd0;
      miss        <= 4'd0;
      data_out    <= 16'h0000;
      word_idx    <= 8'd0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_n;
      fillcnt     <= fillcnt_n;
      bitcnt      <= bitcnt_n;
      wordcnt     <= wordcnt_n;
      miss        <= miss_n;
      data_out    <= dout_n;
      word_idx    <= widx_n;
      data_valid  <= dv_n;
      frame_start <= fs_n;
      sync_err    <= err_n;
      locked      <= lk_n;
    end
  end

endmodule

// File: tb/tb_serial_frame_aligner.sv
// Bench for serial_frame_aligner: word-level vector table, directed
// corner sequences and a random framed stream against a cycle model.
module tb_serial_frame_aligner;

  localparam logic [15:0] SYNC = 16'hA5C3;
  localparam int FW  = 4;
  localparam int LIM = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] sr_word = 16'h0000;
  logic [15:0] data_out;
  logic        data_valid;
  logic [7:0]  word_idx;
  logic        frame_start;
  logic        sync_err;
  logic        locked;

  serial_frame_aligner #(
    .SYNC(SYNC), .FRAME_WORDS(FW), .MISS_LIMIT(LIM)
  ) dut (
    .clk(clk), .resetn(resetn), .sr_word(sr_word),
    .data_out(data_out), .data_valid(data_valid),
    .word_idx(word_idx), .frame_start(frame_start),
    .sync_err(sync_err), .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: absolute cycle numbers; frame positions derived from
  // the cycle in which the last sync was seen (anchor).
  int          cyc = 0;
  bit          started = 0;
  bit          m_lock = 0;
  int          hunt_from = 0;
  int          anchor = 0;
  int          miss = 0;
  logic [15:0] e_dout = '0;
  logic [7:0]  e_idx = '0;
  bit          e_dv, e_fs, e_err;

  task automatic model_step();
    int d, k;
    e_dv = 0; e_fs = 0; e_err = 0;
    if (!resetn) begin
      started = 1;
      m_lock = 0;
      hunt_from = cyc + 17;
      miss = 0;
      e_dout = '0;
      e_idx = '0;
    end else if (!m_lock) begin
      if (cyc >= hunt_from && sr_word == SYNC) begin
        m_lock = 1; anchor = cyc; miss = 0; e_fs = 1;
      end
    end else begin
      d = cyc - anchor;
      if (d % 16 == 0) begin
        k = d / 16 - 1;
        if (k < FW) begin
          e_dv = 1; e_dout = sr_word; e_idx = 8'(k);
        end else if (sr_word == SYNC) begin
          e_fs = 1; miss = 0; anchor = cyc;
        end else begin
          e_err = 1; miss++;
          anchor = cyc;
          if (miss == LIM) begin
            m_lock = 0; hunt_from = cyc + 1;
          end
        end
      end
    end
    cyc++;
  endtask

  // Drive one cycle's inputs, clock it, then compare at the next negedge.
  task automatic cycle(input logic rn, input logic [15:0] sr);
    resetn = rn;
    sr_word = sr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (started)
      chk("model", {36'd0, data_out, data_valid, word_idx,
                    frame_start, sync_err, locked},
          {36'd0, e_dout, e_dv, e_idx, e_fs, e_err, m_lock});
  endtask

  task automatic shift_bit(input logic b);
    cycle(1'b1, {sr_word[14:0], b});
  endtask

  task automatic shift_word(input logic [15:0] w);
    for (int b = 15; b >= 0; b--) shift_bit(w[b]);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, sr_word);
  endtask

  typedef struct {
    logic [15:0] word;
    logic        dv;
    logic [15:0] dout;
    logic [7:0]  idx;
    logic        fs;
    logic        err;
    logic        lk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] w, input logic dv,
                     input logic [15:0] dout, input logic [7:0] idx,
                     input logic fs, input logic err, input logic lk);
    vec_t v;
    v.word = w; v.dv = dv; v.dout = dout; v.idx = idx;
    v.fs = fs; v.err = err; v.lk = lk;
    tbl.push_back(v);
  endtask

  initial begin
    int dvs;
    logic [15:0] w;
    add(16'h0000, 0, 16'h0000, 0, 0, 0, 0);
    add(16'hA5C3, 0, 16'h0000, 0, 1, 0, 1);
    add(16'h1111, 1, 16'h1111, 0, 0, 0, 1);
    add(16'h2222, 1, 16'h2222, 1, 0, 0, 1);
    add(16'h3333, 1, 16'h3333, 2, 0, 0, 1);
    add(16'h4444, 1, 16'h4444, 3, 0, 0, 1);
    add(16'hA5C2, 0, 16'h0000, 0, 0, 1, 1);
    add(16'h5555, 1, 16'h5555, 0, 0, 0, 1);
    add(16'hA5C3, 1, 16'hA5C3, 1, 0, 0, 1);
    add(16'h6666, 1, 16'h6666, 2, 0, 0, 1);
    add(16'h7777, 1, 16'h7777, 3, 0, 0, 1);
    add(16'hA5C3, 0, 16'h0000, 0, 1, 0, 1);
    add(16'h8888, 1, 16'h8888, 0, 0, 0, 1);
    add(16'h9999, 1, 16'h9999, 1, 0, 0, 1);
    add(16'hAAAA, 1, 16'hAAAA, 2, 0, 0, 1);
    add(16'hBBBB, 1, 16'hBBBB, 3, 0, 0, 1);
    add(16'hA5C2, 0, 16'h0000, 0, 0, 1, 1);
    add(16'h0101, 1, 16'h0101, 0, 0, 0, 1);
    add(16'h0202, 1, 16'h0202, 1, 0, 0, 1);
    add(16'h0303, 1, 16'h0303, 2, 0, 0, 1);
    add(16'h0404, 1, 16'h0404, 3, 0, 0, 1);
    add(16'hA5C2, 0, 16'h0000, 0, 0, 1, 0);
    add(16'h0000, 0, 16'h0000, 0, 0, 0, 0);
    add(16'h0000, 0, 16'h0000, 0, 0, 0, 0);
    add(16'hA5C3, 0, 16'h0000, 0, 1, 0, 1);
    add(16'hDDDD, 1, 16'hDDDD, 0, 0, 0, 1);

    @(negedge clk);
    do_reset(3);
    chk("reset_outs", {36'd0, data_out, data_valid, word_idx,
                       frame_start, sync_err, locked}, 64'd0);

    foreach (tbl[i]) begin
      shift_word(tbl[i].word);
      chk($sformatf("vec%0d_dv", i), 64'(data_valid), 64'(tbl[i].dv));
      chk($sformatf("vec%0d_fs", i), 64'(frame_start), 64'(tbl[i].fs));
      chk($sformatf("vec%0d_err", i), 64'(sync_err), 64'(tbl[i].err));
      chk($sformatf("vec%0d_lk", i), 64'(locked), 64'(tbl[i].lk));
      if (tbl[i].dv)
        chk($sformatf("vec%0d_data", i), {40'd0, data_out, word_idx},
            {40'd0, tbl[i].dout, tbl[i].idx});
    end
    chk("hold_after_loss", 64'(data_out), 64'(16'hDDDD));

    // sync held constant through reset: first match only in cycle 18
    do_reset(2);
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, SYNC);
      chk($sformatf("hold_fs_c%0d", i + 1), 64'(frame_start),
          64'(i == 17));
    end

    // reset at bit 7 of word 2 discards that word
    do_reset(2);
    shift_word(16'h0000);
    shift_word(16'hA5C3);
    shift_word(16'h1111);
    shift_word(16'h2222);
    w = 16'h3333;
    for (int b = 15; b >= 8; b--) shift_bit(w[b]);
    cycle(1'b0, {sr_word[14:0], w[7]});
    chk("midreset_outs", {36'd0, data_out, data_valid, word_idx,
                          frame_start, sync_err, locked}, 64'd0);
    dvs = 0;
    for (int b = 6; b >= 0; b--) begin
      shift_bit(w[b]);
      dvs += int'(data_valid);
    end
    chk("midreset_no_dv", 64'(dvs), 64'd0);
    for (int b = 0; b < 9; b++) shift_bit(1'b0);
    shift_word(16'h0000);
    shift_word(16'hA5C3);
    chk("reacq_fs", 64'(frame_start), 64'd1);
    shift_word(16'h1111);
    chk("reacq_word0", {47'd0, data_valid, data_out},
        {47'd0, 1'b1, 16'h1111});

    // random framed stream with corrupted syncs, fake syncs, resets
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 19) == 0)
        do_reset($urandom_range(1, 2));
      for (int g = $urandom_range(0, 20); g > 0; g--)
        shift_bit(1'($urandom));
      w = SYNC;
      if ($urandom_range(0, 3) == 0)
        w[$urandom_range(0, 15)] ^= 1'b1;
      shift_word(w);
      for (int k = 0; k < FW; k++) begin
        w = ($urandom_range(0, 7) == 0) ? SYNC : 16'($urandom);
        shift_word(w);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             checks, errs);
    $finish;
  end

endmodule
